// File: rtl/morse_timing_ctrl.sv
`default_nettype none
// morse_timing_ctrl: Morse key timing sequencer. It calibrates the dot/dash threshold,
// classifies presses, detects letter gaps and hands each letter off with valid/ack.
module morse_timing_ctrl #(
  parameter int               CNT_W      = 16,
  parameter int               CAL_N_LOG2 = 2,
  parameter int               MAX_SYMS   = 5,
  parameter logic [CNT_W-1:0] DEF_THRESH = CNT_W'(11)
) (
  input  logic                ClkPort,
  input  logic                Resetn,
  input  logic                Tick,
  input  logic                Key,
  input  logic                CalMode,
  input  logic                DecodeMode,
  input  logic                Letter_ack,
  output logic                Letter_valid,
  output logic [MAX_SYMS-1:0] Letter_code,
  output logic [2:0]          Letter_len,
  output logic                Letter_err,
  output logic [CNT_W-1:0]    Threshold,
  output logic                Cal_done,
  output logic                Cal_err,
  output logic                Overrun,
  output logic [2:0]          State
);

  localparam int SUM_W = CNT_W + CAL_N_LOG2 + 1;
  localparam int CAL_N = 1 << CAL_N_LOG2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAL_S     = 3'd1,
    S_CAL_L     = 3'd2,
    S_CALC      = 3'd3,
    S_DEC_GAP   = 3'd4,
    S_DEC_PRESS = 3'd5,
    S_EMIT      = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_key_q;
  logic [CNT_W-1:0]      r_dur;
  logic [CNT_W-1:0]      r_gap;
  logic [CNT_W-1:0]      r_thresh;
  logic [SUM_W-1:0]      r_sum_s;
  logic [SUM_W-1:0]      r_sum_l;
  logic [CAL_N_LOG2-1:0] r_idx;
  logic                  r_cal_done;
  logic                  r_cal_err;
  logic [MAX_SYMS-1:0]   r_code;
  logic [2:0]            r_len;
  logic                  r_err;
  logic                  r_overrun;

  logic                  w_rise;
  logic                  w_fall;
  logic [CNT_W-1:0]      w_dur_next;
  logic [CNT_W-1:0]      w_gap_next;
  logic                  w_dash;
  logic                  w_len_full;
  logic [MAX_SYMS-1:0]   w_sym_mask;
  logic                  w_cal_start;
  logic                  w_add_s;
  logic                  w_add_l;
  logic                  w_calc;
  logic                  w_buf_clr;
  logic                  w_append;
  logic                  w_set_err;
  logic                  w_overrun;

  assign w_rise = Key & ~r_key_q;
  assign w_fall = ~Key & r_key_q;

  // The fall cycle still counts as pressed, so the captured duration is the next value.
  assign w_dur_next = (Tick && r_key_q && (r_dur != '1)) ? r_dur + CNT_W'(1) : r_dur;
  assign w_gap_next = (Tick && !r_key_q && (r_gap != '1)) ? r_gap + CNT_W'(1) : r_gap;

  assign w_dash     = (w_dur_next >= r_thresh);
  assign w_len_full = (r_len == 3'(MAX_SYMS));
  assign w_sym_mask = w_dash ? (MAX_SYMS'(1) << r_len) : '0;

  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      r_key_q <= 1'b0;
      r_dur   <= '0;
      r_gap   <= '0;
    end else begin
      r_key_q <= Key;
      r_dur   <= w_rise ? '0 : w_dur_next;
      r_gap   <= w_fall ? '0 : w_gap_next;
    end
  end

  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cal_start = 1'b0;
    w_add_s     = 1'b0;
    w_add_l     = 1'b0;
    w_calc      = 1'b0;
    w_buf_clr   = 1'b0;
    w_append    = 1'b0;
    w_set_err   = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CalMode) begin
          w_state_nxt = S_CAL_S;
          w_cal_start = 1'b1;
        end else if (DecodeMode && r_cal_done) begin
          w_state_nxt = S_DEC_GAP;
          w_buf_clr   = 1'b1;
        end
      end
      S_CAL_S: begin
        if (!CalMode) begin
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_add_s = 1'b1;
          if (r_idx == CAL_N_LOG2'(CAL_N - 1)) w_state_nxt = S_CAL_L;
        end
      end
      S_CAL_L: begin
        if (!CalMode) begin
          w_state_nxt = S_IDLE;
        end else if (w_fall) begin
          w_add_l = 1'b1;
          if (r_idx == CAL_N_LOG2'(CAL_N - 1)) w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_DEC_GAP: begin
        if (!DecodeMode || CalMode) begin
          w_state_nxt = S_IDLE;
          w_buf_clr   = 1'b1;
        end else if (w_rise) begin
          w_state_nxt = S_DEC_PRESS;
        end else if ((r_len != 3'd0) && (w_gap_next >= r_thresh)) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_DEC_PRESS: begin
        if (!DecodeMode || CalMode) begin
          w_state_nxt = S_IDLE;
          w_buf_clr   = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = S_DEC_GAP;
          if (w_len_full) w_set_err = 1'b1;
          else            w_append  = 1'b1;
        end
      end
      S_EMIT: begin
        // A press starting while a letter waits is dropped; no rise is seen for it later.
        if (w_rise) w_overrun = 1'b1;
        if (Letter_ack) begin
          w_state_nxt = S_DEC_GAP;
          w_buf_clr   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      r_sum_s    <= '0;
      r_sum_l    <= '0;
      r_idx      <= '0;
      r_thresh   <= DEF_THRESH;
      r_cal_done <= 1'b0;
      r_cal_err  <= 1'b0;
    end else begin
      if (w_cal_start) begin
        r_sum_s   <= '0;
        r_sum_l   <= '0;
        r_idx     <= '0;
        r_cal_err <= 1'b0;
      end
      if (w_add_s) begin
        r_sum_s <= r_sum_s + SUM_W'(w_dur_next);
        r_idx   <= r_idx + CAL_N_LOG2'(1);
      end
      if (w_add_l) begin
        r_sum_l <= r_sum_l + SUM_W'(w_dur_next);
        r_idx   <= r_idx + CAL_N_LOG2'(1);
      end
      if (w_calc) begin
        if (r_sum_l > r_sum_s) begin
          r_thresh   <= CNT_W'((r_sum_s + r_sum_l) >> (CAL_N_LOG2 + 1));
          r_cal_done <= 1'b1;
        end else begin
          r_cal_err  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      r_code    <= '0;
      r_len     <= 3'd0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_buf_clr) begin
        r_code <= '0;
        r_len  <= 3'd0;
        r_err  <= 1'b0;
      end else if (w_append) begin
        r_code <= r_code | w_sym_mask;
        r_len  <= r_len + 3'd1;
      end else if (w_set_err) begin
        r_err  <= 1'b1;
      end
    end
  end

  assign Letter_valid = (r_state == S_EMIT);
  assign Letter_code  = r_code;
  assign Letter_len   = r_len;
  assign Letter_err   = r_err;
  assign Threshold    = r_thresh;
  assign Cal_done     = r_cal_done;
  assign Cal_err      = r_cal_err;
  assign Overrun      = r_overrun;
  assign State        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_morse_timing_ctrl.sv
`default_nettype none
// Bench for morse_timing_ctrl: directed and randomised presses checked against a
// model built from press durations, calibration sums and the gap rule.
module tb_morse_timing_ctrl;
  localparam int CAL_N      = 4;
  localparam int MAX_SYMS   = 5;
  localparam int DEF_THRESH = 11;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        tick     = 1'b1;
  logic        key      = 1'b0;
  logic        cal_mode = 1'b0;
  logic        dec_mode = 1'b0;
  logic        ack      = 1'b0;
  logic        valid;
  logic [4:0]  code;
  logic [2:0]  len;
  logic        err;
  logic [15:0] thr;
  logic        cal_done;
  logic        cal_err;
  logic        overrun;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int q_dur[$];
  int ref_thr  = DEF_THRESH;
  bit ref_done = 1'b0;
  logic [4:0] exp_code;
  int exp_len;

  morse_timing_ctrl #(
    .CNT_W(16), .CAL_N_LOG2(2), .MAX_SYMS(5), .DEF_THRESH(16'd11)
  ) dut (
    .ClkPort(clk), .Resetn(rst_n), .Tick(tick), .Key(key),
    .CalMode(cal_mode), .DecodeMode(dec_mode), .Letter_ack(ack),
    .Letter_valid(valid), .Letter_code(code), .Letter_len(len), .Letter_err(err),
    .Threshold(thr), .Cal_done(cal_done), .Cal_err(cal_err),
    .Overrun(overrun), .State(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key high across n rising edges gives a measured duration of n.
  task automatic press(input int n);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic calibrate(input int smin, input int smax, input int lmin, input int lmax,
                           input string tag);
    int ss, sl, d;
    bit exp_err;
    ss = 0;
    sl = 0;
    cal_mode = 1'b1;
    @(negedge clk);
    check({tag, "_err_clear"}, cal_err, 0);
    for (int i = 0; i < 2 * CAL_N; i++) begin
      if (i < CAL_N) begin
        d = $urandom_range(smax, smin);
        ss += d;
      end else begin
        d = $urandom_range(lmax, lmin);
        sl += d;
      end
      press(d);
      if (i != 2 * CAL_N - 1) idle(3);
    end
    @(negedge clk);
    cal_mode = 1'b0;
    check({tag, "_busy_after_last_fall"}, (state != 3'd0), 1);
    @(negedge clk);
    exp_err = 1'b1;
    if (sl > ss) begin
      ref_thr  = (ss + sl) / (2 * CAL_N);
      ref_done = 1'b1;
      exp_err  = 1'b0;
    end
    check({tag, "_state_idle"}, state, 0);
    check({tag, "_threshold"}, thr, ref_thr);
    check({tag, "_cal_done"}, cal_done, ref_done);
    check({tag, "_cal_err"}, cal_err, exp_err);
  endtask

  task automatic send_letter(input int gap);
    int n;
    n = q_dur.size();
    for (int i = 0; i < n; i++) begin
      press(q_dur[i]);
      if (i != n - 1) idle((gap > 0) ? gap : int'($urandom_range(ref_thr, 1)));
    end
  endtask

  task automatic expect_letter(input string tag);
    int n;
    logic e;
    n = q_dur.size();
    exp_code = '0;
    for (int i = 0; i < n && i < MAX_SYMS; i++) exp_code[i] = (q_dur[i] >= ref_thr);
    exp_len = (n > MAX_SYMS) ? MAX_SYMS : n;
    e = (n > MAX_SYMS);
    repeat (ref_thr) @(negedge clk);
    check({tag, "_valid_early"}, valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_code"}, code, exp_code);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_err"}, err, e);
  endtask

  task automatic ack_letter(input int hold, input string tag);
    repeat (hold) @(negedge clk);
    check({tag, "_valid_held"}, valid, 1);
    check({tag, "_code_held"}, code, exp_code);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_buf_clear"}, len, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_code", code, 0);
    check("rst_len", len, 0);
    check("rst_err", err, 0);
    check("rst_thr", thr, DEF_THRESH);
    check("rst_cal_done", cal_done, 0);
    check("rst_cal_err", cal_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Calibration: 4 x 2-cycle shorts, 4 x 20-cycle longs
    calibrate(2, 2, 20, 20, "t1");
    check("t1_thr_is_11", thr, 11);

    // Letter A
    dec_mode = 1'b1;
    @(negedge clk);
    q_dur = '{2, 20};
    send_letter(2);
    expect_letter("t2");
    ack_letter(3, "t2");

    // Threshold boundary and symbol overflow
    q_dur = '{10, 11};
    send_letter(2);
    expect_letter("t4_bound");
    ack_letter(0, "t4_bound");
    q_dur = '{2, 2, 2, 2, 2, 2};
    send_letter(2);
    expect_letter("t4_six");
    ack_letter(1, "t4_six");

    // Overrun while a letter waits
    q_dur = '{20};
    send_letter(2);
    expect_letter("t5a");
    key = 1'b1;
    @(negedge clk);
    check("t5_overrun_pulse", overrun, 1);
    check("t5_code_kept", code, exp_code);
    @(negedge clk);
    check("t5_overrun_once", overrun, 0);
    key = 1'b0;
    @(negedge clk);
    check("t5_len_kept", len, 1);
    ack_letter(0, "t5a");
    q_dur = '{2};
    send_letter(2);
    expect_letter("t5b");
    ack_letter(2, "t5b");

    // Bad calibration keeps the earlier result
    dec_mode = 1'b0;
    @(negedge clk);
    calibrate(20, 20, 2, 2, "t3_bad");

    // Bad calibration from reset: decode must stay refused
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    ref_thr  = DEF_THRESH;
    ref_done = 1'b0;
    @(negedge clk);
    calibrate(20, 20, 2, 2, "t3_rst");
    dec_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_decode_refused", state, 0);
    dec_mode = 1'b0;
    @(negedge clk);

    // Randomised calibration and letters
    calibrate(1, 8, 12, 40, "rnd_cal");
    dec_mode = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(7, 1);
      q_dur.delete();
      for (int i = 0; i < n; i++) q_dur.push_back(int'($urandom_range(2 * ref_thr, 1)));
      send_letter(0);
      expect_letter($sformatf("rnd%0d", k));
      ack_letter($urandom_range(3, 0), $sformatf("rnd%0d", k));
    end
    dec_mode = 1'b0;
    @(negedge clk);

    // Calibration abort after three shorts
    cal_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      press(2);
      idle(3);
    end
    cal_mode = 1'b0;
    @(negedge clk);
    check("t6_abort_idle", state, 0);
    check("t6_abort_thr", thr, ref_thr);
    check("t6_abort_done", cal_done, 1);

    // Asynchronous reset mid-letter
    dec_mode = 1'b1;
    @(negedge clk);
    press(3);
    idle(2);
    check("t6_partial_len", len, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_len", len, 0);
    check("t6_rst_code", code, 0);
    check("t6_rst_state", state, 0);
    check("t6_rst_done", cal_done, 0);
    check("t6_rst_thr", thr, DEF_THRESH);
    check("t6_rst_valid", valid, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    dec_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_post_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
